fifo: RTL and testbench



---
 rtl/fifo.sv | 61 ++++++
 tb/tb_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data and full/empty flags.
// Pointers wrap modulo DEPTH; the occupancy counter resolves full vs empty.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  full,
  output logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  // Storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed and scoreboard-checked bench for the 16 x 8 FIFO.
module tb_fifo;

  logic       clock;
  logic       rd;
  logic       wr;
  logic       full;
  logic       empty;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rst;

  int compare_count;
  int fail_count;

  logic [7:0] model_q[$];
  logic [7:0] model_out;

  fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clock    (clock),
    .rd       (rd),
    .wr       (wr),
    .full     (full),
    .empty    (empty),
    .data_in  (data_in),
    .data_out (data_out),
    .rst      (rst)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge and are held across the next one.
  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] d);
    rd      = r;
    wr      = w;
    data_in = d;
    @(posedge clock);
    #1;
    rd      = 1'b0;
    wr      = 1'b0;
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    rd            = 1'b0;
    wr            = 1'b0;
    data_in       = '0;
    rst           = 1'b0;

    // Reset state, then idle after release
    #2;
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_data_out", 32'(data_out), 32'h00);
    #5 rst = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("idle_empty", 32'(empty), 32'd1);
    checkOutput("idle_full", 32'(full), 32'd0);
    checkOutput("idle_data_out", 32'(data_out), 32'h00);

    // Fill with 0x01..0x10, then a dropped overflow write
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i));
      if (i == 15) checkOutput("fill15_full", 32'(full), 32'd0);
      if (i == 1) checkOutput("fill1_empty", 32'(empty), 32'd0);
    end
    checkOutput("fill16_full", 32'(full), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    checkOutput("overflow_full", 32'(full), 32'd1);
    checkOutput("overflow_data_out", 32'(data_out), 32'h00);

    // Drain in order, then an underflow read
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
      if (i == 1) checkOutput("drain1_full", 32'(full), 32'd0);
      if (i == 15) checkOutput("drain15_empty", 32'(empty), 32'd0);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("underflow_data_out", 32'(data_out), 32'h10);
    checkOutput("underflow_empty", 32'(empty), 32'd1);

    // Simultaneous rd&wr with 4 entries held
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'h21 + i));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h31 + i));
      checkOutput($sformatf("simul_rd_%0d", i), 32'(data_out),
                  (i < 4) ? 32'(8'h21 + i) : 32'h31);
      checkOutput($sformatf("simul_empty_%0d", i), 32'(empty), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("simul_drain_%0d", i), 32'(data_out), 32'(8'h32 + i));
      checkOutput($sformatf("simul_drain_empty_%0d", i), 32'(empty), (i == 3) ? 32'd1 : 32'd0);
    end

    // Simultaneous on empty: write only, no fall-through
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("empty_rw_data_out", 32'(data_out), 32'h35);
    checkOutput("empty_rw_empty", 32'(empty), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("empty_rw_read", 32'(data_out), 32'hAA);
    checkOutput("empty_rw_after", 32'(empty), 32'd1);

    // Simultaneous on full: read only, the write is dropped
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h40 + i));
    applyStimulus(1'b1, 1'b1, 8'hEE);
    checkOutput("full_rw_data_out", 32'(data_out), 32'h40);
    checkOutput("full_rw_full", 32'(full), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      if (i == 15) checkOutput("full_rw_last", 32'(data_out), 32'h4F);
    end
    checkOutput("full_rw_empty", 32'(empty), 32'd1);

    // Random traffic against a queue model, crossing the wrap point many times
    model_q.delete();
    model_out = 8'h4F;
    for (int i = 0; i < 100; i++) begin
      logic       r;
      logic       w;
      logic [7:0] d;
      logic       rd_ok;
      logic       wr_ok;
      r     = ($urandom_range(0, 99) < 45);
      w     = ($urandom_range(0, 99) < 55);
      d     = 8'($urandom);
      rd_ok = r && (model_q.size() != 0);
      wr_ok = w && (model_q.size() != 16);
      applyStimulus(r, w, d);
      if (rd_ok) model_out = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      checkOutput($sformatf("rand_data_%0d", i), 32'(data_out), 32'(model_out));
      checkOutput($sformatf("rand_empty_%0d", i), 32'(empty), 32'(model_q.size() == 0));
      checkOutput($sformatf("rand_full_%0d", i), 32'(full), 32'(model_q.size() == 16));
    end

    // Asynchronous reset between edges with entries present
    while (model_q.size() > 0) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      void'(model_q.pop_front());
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h51 + i));
    #2 rst = 1'b0;
    #1;
    checkOutput("async_empty", 32'(empty), 32'd1);
    checkOutput("async_full", 32'(full), 32'd0);
    checkOutput("async_data_out", 32'(data_out), 32'h00);
    #1 rst = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 1'b1, 8'h66);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("post_reset_read", 32'(data_out), 32'h66);
    checkOutput("post_reset_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
